// File: rtl/prng_sched_pkg.sv
// rtl/prng_sched_pkg.sv - shared state encoding and width helper for prng_scheduler
package prng_sched_pkg;

  typedef enum logic {
    ST_FILL  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting after ptr
module rr_arbiter
  import prng_sched_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [PW-1:0] idx,
  output logic          any
);

  always_comb begin
    logic [PW-1:0] w_j;
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    w_j    = '0;
    // Scan ptr+1 .. ptr+N (mod N); the first hit wins.
    for (int k = 1; k <= N; k++) begin
      w_j = PW'((int'(ptr) + k) % N);
      if (!any && req[w_j]) begin
        any         = 1'b1;
        onehot[w_j] = 1'b1;
        idx         = w_j;
      end
    end
  end

endmodule

// File: rtl/prng_scheduler.sv
// rtl/prng_scheduler.sv - packs prng chunks into words and hands each to one requester round-robin
module prng_scheduler
  import prng_sched_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int OUTPUT_BITS = 2,
  parameter int WORD_BITS   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [OUTPUT_BITS-1:0] prng_random,
  output logic                   prng_entropy,
  input  logic [NUM_REQ-1:0]     ent_in,
  input  logic [NUM_REQ-1:0]     req,
  output logic [NUM_REQ-1:0]     grant,
  output logic                   valid,
  output logic [WORD_BITS-1:0]   word
);

  localparam int CHUNKS = WORD_BITS / OUTPUT_BITS;
  localparam int CNT_W  = clog2(CHUNKS + 1);
  localparam int PW     = (NUM_REQ > 1) ? clog2(NUM_REQ) : 1;

  state_t               r_state, w_state_nxt;
  logic [CNT_W-1:0]     r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [WORD_BITS-1:0] r_buf, w_buf_nxt, w_shift;
  logic [WORD_BITS-1:0] r_word, w_word_nxt;
  logic [NUM_REQ-1:0]   r_grant, w_grant_nxt;
  logic                 r_valid, w_valid_nxt;
  logic [PW-1:0]        r_ptr, w_ptr_nxt;
  logic                 r_ent;
  logic [NUM_REQ-1:0]   w_onehot;
  logic [PW-1:0]        w_idx;
  logic                 w_any;

  rr_arbiter #(.N(NUM_REQ), .PW(PW)) u_arb (
    .req    (req),
    .ptr    (r_ptr),
    .onehot (w_onehot),
    .idx    (w_idx),
    .any    (w_any)
  );

  // Newest chunk enters at the LSBs, so the first chunk ends in the MSBs.
  generate
    if (CHUNKS == 1) begin : g_direct
      assign w_shift = prng_random;
    end else begin : g_shift
      assign w_shift = {r_buf[WORD_BITS-OUTPUT_BITS-1:0], prng_random};
    end
  endgenerate

  assign w_cnt_inc = r_cnt + CNT_W'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_buf_nxt   = r_buf;
    w_word_nxt  = r_word;
    w_grant_nxt = '0;
    w_valid_nxt = 1'b0;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      ST_FILL: begin
        w_buf_nxt = w_shift;
        w_cnt_nxt = w_cnt_inc;
        if (w_cnt_inc == CNT_W'(CHUNKS)) w_state_nxt = ST_READY;
      end
      ST_READY: begin
        if (w_any) begin
          w_grant_nxt = w_onehot;
          w_valid_nxt = 1'b1;
          w_word_nxt  = r_buf;
          w_ptr_nxt   = w_idx;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_FILL;
        end
      end
      default: w_state_nxt = ST_FILL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_FILL;
      r_cnt   <= '0;
      r_buf   <= '0;
      r_word  <= '0;
      r_grant <= '0;
      r_valid <= 1'b0;
      r_ptr   <= PW'(NUM_REQ - 1);
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_buf   <= w_buf_nxt;
      r_word  <= w_word_nxt;
      r_grant <= w_grant_nxt;
      r_valid <= w_valid_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_ent <= 1'b0;
    else     r_ent <= ^ent_in;
  end

  assign prng_entropy = r_ent;
  assign grant        = r_grant;
  assign valid        = r_valid;
  assign word         = r_word;

endmodule
